// File: rtl/dec7seg_mux_if.sv
// Display bus between a datapath/debug source and the multiplexed 7-segment driver.
// The master drives value/strobe/enable; the slave returns segment, point and anode pins.
interface dec7seg_mux_if #(
    parameter int P_DIGITS = 4
) ();
    logic                    en;
    logic                    load;
    logic [4*P_DIGITS-1:0]   value;
    logic [P_DIGITS-1:0]     dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [P_DIGITS-1:0]     an;

    modport master (
        output en, load, value, dp_in,
        input  seg, dp, an
    );

    modport slave (
        input  en, load, value, dp_in,
        output seg, dp, an
    );
endinterface

// File: rtl/dec7seg_mux.sv
// Time-multiplexed hex driver for common-anode 7-segment displays, active-low outputs.
// Optional leading-zero blanking is enabled by defining DEC7SEG_LZ_BLANK_EN.
module dec7seg_mux #(
    parameter int P_DIGITS = 4,
    parameter int P_DIV    = 50000
) (
    input  logic            clk,
    input  logic            rst,
    dec7seg_mux_if.slave    bus
);
    localparam int DIV_W = $clog2(P_DIV);
    localparam int IDX_W = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_DIGITS - 1);

    logic [4*P_DIGITS-1:0] r_val;
    logic [P_DIGITS-1:0]   r_dp;
    logic [DIV_W-1:0]      r_div;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_live;
    logic [6:0]            r_seg;
    logic                  r_dpOut;
    logic [P_DIGITS-1:0]   r_an;

    logic [3:0]            w_nibble;
    logic                  w_dpSel;
    logic [P_DIGITS-1:0]   w_anSel;
    logic [6:0]            w_segDec;
    logic                  w_lzHide;
    logic                  w_blank;

    always_comb begin
        w_nibble = 4'h0;
        w_dpSel  = 1'b0;
        for (int i = 0; i < P_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_val[4*i +: 4];
                w_dpSel  = r_dp[i];
            end
        end
    end

    assign w_anSel = ~(P_DIGITS'(1) << r_idx);

    always_comb begin
        case (w_nibble)
            4'h0: w_segDec = 7'h40;
            4'h1: w_segDec = 7'h79;
            4'h2: w_segDec = 7'h24;
            4'h3: w_segDec = 7'h30;
            4'h4: w_segDec = 7'h19;
            4'h5: w_segDec = 7'h12;
            4'h6: w_segDec = 7'h02;
            4'h7: w_segDec = 7'h78;
            4'h8: w_segDec = 7'h00;
            4'h9: w_segDec = 7'h10;
            4'hA: w_segDec = 7'h08;
            4'hB: w_segDec = 7'h03;
            4'hC: w_segDec = 7'h46;
            4'hD: w_segDec = 7'h21;
            4'hE: w_segDec = 7'h06;
            default: w_segDec = 7'h0E;
        endcase
    end

`ifdef DEC7SEG_LZ_BLANK_EN
    // Walk down from the top digit: a digit is a leading zero while every nibble above it is zero too.
    always_comb begin
        logic zeroRun;
        zeroRun  = 1'b1;
        w_lzHide = 1'b0;
        for (int i = P_DIGITS - 1; i >= 1; i--) begin
            zeroRun = zeroRun & (r_val[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_lzHide = zeroRun & ~r_dp[i];
            end
        end
    end
`else
    assign w_lzHide = 1'b0;
`endif

    // Blanking on the last divider cycle keeps the old segments off the next anode.
    assign w_blank = (r_div == DIV_LAST) | ~bus.en | ~r_live | w_lzHide;

    // r_live holds the display dark for the first edge after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val   <= '0;
            r_dp    <= '0;
            r_div   <= '0;
            r_idx   <= '0;
            r_live  <= 1'b0;
            r_seg   <= 7'h7F;
            r_dpOut <= 1'b1;
            r_an    <= '1;
        end else begin
            if (bus.load) begin
                r_val <= bus.value;
                r_dp  <= bus.dp_in;
            end
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_live <= 1'b1;
            if (w_blank) begin
                r_seg   <= 7'h7F;
                r_dpOut <= 1'b1;
                r_an    <= '1;
            end else begin
                r_seg   <= w_segDec;
                r_dpOut <= ~w_dpSel;
                r_an    <= w_anSel;
            end
        end
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dpOut;
    assign bus.an  = r_an;
endmodule

// File: tb/tb_dec7seg_mux.sv
// Scoreboard bench for dec7seg_mux: a cycle model predicts {an,seg,dp} for every edge.
// Honours DEC7SEG_LZ_BLANK_EN the same way the design does.
module tb_dec7seg_mux;
    localparam int P_DIGITS = 4;
    localparam int P_DIV    = 4;
    localparam logic [11:0] BLANK = {4'hF, 7'h7F, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dec7seg_mux_if #(.P_DIGITS(P_DIGITS)) bus ();

    dec7seg_mux #(.P_DIGITS(P_DIGITS), .P_DIV(P_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [11:0] expQ [$];

    int          mDiv  = 0;
    int          mIdx  = 0;
    logic [15:0] mVal  = '0;
    logic [3:0]  mDp   = '0;
    bit          mLive = 1'b0;

    task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit lzHide(input int idx);
`ifdef DEC7SEG_LZ_BLANK_EN
        if (idx == 0) return 1'b0;
        for (int j = idx; j < P_DIGITS; j++) begin
            if (mVal[4*j +: 4] != 4'h0) return 1'b0;
        end
        return !mDp[idx];
`else
        return 1'b0;
`endif
    endfunction

    // Predict the output produced at the coming edge, then advance the model past it.
    task automatic applyStimulus(input string tag, input bit iRst, input bit iEn, input bit iLoad,
                                 input logic [15:0] iValue, input logic [3:0] iDp);
        logic [11:0] exp;
        logic [3:0]  anExp;
        @(negedge clk);
        rst       = iRst;
        bus.en    = iEn;
        bus.load  = iLoad;
        bus.value = iValue;
        bus.dp_in = iDp;
        anExp = ~(4'b0001 << mIdx);
        if (iRst || !mLive || mDiv == P_DIV - 1 || !iEn || lzHide(mIdx))
            exp = BLANK;
        else
            exp = {anExp, segTable[mVal[4*mIdx +: 4]], ~mDp[mIdx]};
        expQ.push_back(exp);
        if (iRst) begin
            mDiv = 0; mIdx = 0; mVal = '0; mDp = '0; mLive = 1'b0;
        end else begin
            if (iLoad) begin
                mVal = iValue;
                mDp  = iDp;
            end
            if (mDiv == P_DIV - 1) begin
                mDiv = 0;
                mIdx = (mIdx + 1) % P_DIGITS;
            end else begin
                mDiv++;
            end
            mLive = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput(tag, {bus.an, bus.seg, bus.dp}, expQ.pop_front());
    endtask

    task automatic idle(input string tag, input int n, input bit iEn);
        repeat (n) applyStimulus(tag, 1'b0, iEn, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic alignTo(input string tag, input int idx, input int div);
        int n = 0;
        while (!(mIdx == idx && mDiv == div) && n < 64) begin
            idle(tag, 1, 1'b1);
            n++;
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0;

        applyStimulus("porReset", 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        applyStimulus("porReset", 1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        applyStimulus("preLoad", 1'b0, 1'b1, 1'b1, 16'h9C27, 4'b0011);
        idle("preScan", 9, 1'b1);

        repeat (3) applyStimulus("midReset", 1'b1, 1'b1, 1'b0, 16'hFFFF, 4'hF);
        checkOutput("resetBlank", {bus.an, bus.seg, bus.dp}, BLANK);
        idle("release", 1, 1'b1);
        checkOutput("releaseDark", {bus.an, bus.seg, bus.dp}, BLANK);
        idle("release", 1, 1'b1);
        checkOutput("releaseLit", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'h40, 1'b1});

        applyStimulus("scanLoad", 1'b0, 1'b1, 1'b1, 16'h1A3F, 4'b0100);
        idle("scan", 2 * P_DIGITS * P_DIV, 1'b1);
        alignTo("scanAlign", 2, 0);
        idle("scan", 1, 1'b1);
        checkOutput("scanDigit2", {bus.an, bus.seg, bus.dp}, {4'b1011, 7'h08, 1'b0});

        alignTo("ldAlign", 0, P_DIV - 1);
        applyStimulus("ldEdge", 1'b0, 1'b1, 1'b1, 16'h0008, 4'b0000);
        idle("ldNext", 1, 1'b1);
        checkOutput("ldNextDigit", {bus.an, bus.seg, bus.dp}, {4'b1101, 7'h40, 1'b1});
        alignTo("ldAlign0", 0, 0);
        idle("ldDigit0", 1, 1'b1);
        checkOutput("ldDigit0", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'h00, 1'b1});

        applyStimulus("enLoad", 1'b0, 1'b1, 1'b1, 16'h4321, 4'b1000);
        idle("enLow", 6, 1'b0);
        idle("enHigh", 2 * P_DIGITS * P_DIV, 1'b1);

        for (int v = 0; v < 16; v++) begin
            applyStimulus("decLoad", 1'b0, 1'b1, 1'b1, {4'(15 - v), 8'h00, 4'(v)}, 4'b0000);
            alignTo("decAlign", 0, 0);
            idle("decShow", 1, 1'b1);
            checkOutput("decode", {5'b0, bus.seg}, {5'b0, segTable[v]});
        end

        applyStimulus("lzLoad", 1'b0, 1'b1, 1'b1, 16'h0050, 4'b0000);
        alignTo("lzAlign1", 1, 0);
        idle("lzDigit1", 1, 1'b1);
        checkOutput("lzDigit1", {bus.an, bus.seg, bus.dp}, {4'b1101, 7'h12, 1'b1});
        alignTo("lzAlign3", 3, 0);
        idle("lzDigit3", 1, 1'b1);
`ifdef DEC7SEG_LZ_BLANK_EN
        checkOutput("lzDigit3", {bus.an, bus.seg, bus.dp}, BLANK);
`else
        checkOutput("lzDigit3", {bus.an, bus.seg, bus.dp}, {4'b0111, 7'h40, 1'b1});
`endif
        idle("lzScan", P_DIGITS * P_DIV, 1'b1);
        applyStimulus("lzZero", 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0000);
        idle("lzZeroScan", 2 * P_DIGITS * P_DIV, 1'b1);
        applyStimulus("lzDp", 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0100);
        idle("lzDpScan", P_DIGITS * P_DIV, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule

// File: doc/dec7seg_mux.md
# dec7seg_mux

Time-multiplexed hex driver for a bank of common-anode 7-segment displays. Holds a `P_DIGITS`-nibble value captured on a load strobe and scans the digits one at a time at a programmable refresh rate. Each nibble is decoded to an active-low segment pattern with a per-digit decimal point. It sits between datapath/debug registers and the board display pins, replacing one combinational decoder per digit.

## Interface
- `P_DIGITS`, 4: number of digits scanned, 1..8.
- `P_DIV`, 50000: clock cycles each digit stays lit, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  display enable; low blanks every digit, scanning continues.
- `load`  in  1  one-cycle strobe; captures `value` and `dp_in`.
- `value`  in  4*P_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) → digit i, digit 0 = least significant.
- `dp_in`  in  P_DIGITS  decimal point per digit, 1 = lit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  P_DIGITS  digit anode select, active-low, at most one bit low.

## Operation
- Shadow registers `val_q`, `dp_q` load `value`/`dp_in` when `load`=1. They hold otherwise. `value` is ignored between strobes.
- Divider `div_q` counts 0..P_DIV-1 and wraps. When `div_q`=P_DIV-1, digit index `idx_q` advances: i→i+1, P_DIGITS-1→0.
- Decode (hex→seg): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E. Values in hex, bit6=g … bit0=a.
- Anti-ghosting: during the cycle where `div_q`=P_DIV-1, the registered outputs are driven blank: `an`=all 1, `seg`=7F, `dp`=1.
- Otherwise, for each cycle:
  - `an` = ~(1<<idx_q).
  - `seg` = decode(val_q nibble idx_q).
  - `dp` = ~dp_q[idx_q].
- `en`=0 forces blank outputs (`an`=all 1, `seg`=7F, `dp`=1). `div_q`/`idx_q` keep running.
- Reset: `val_q`=0, `dp_q`=0, `div_q`=0, `idx_q`=0, `seg`=7F, `dp`=1, `an`=all 1.
- Width rules: `div_q` is clog2(P_DIV) bits. `idx_q` is max(1,clog2(P_DIGITS)) bits. For P_DIGITS=1, `idx_q` stays 0 and the digit blanks one cycle per period.

## Timing
- All outputs are registered. `seg`/`dp`/`an` reflect `idx_q`, `div_q`, `val_q` and `en` as sampled at the previous edge: 1-cycle latency.
- `load` at edge N updates `val_q` at N. The new value is visible on the outputs of the currently selected digit from edge N+1.
- `load` coinciding with an index advance: the new `val_q` and the new `idx_q` both apply. The output at N+1 shows the new digit with the new value.
- `load` held high captures every cycle; the last capture wins.
- `rst` mid-scan: the next edge restores all reset values. The first lit cycle after release is edge 2: digit 0, `seg`=40.
- Full scan period = P_DIGITS×P_DIV cycles. Each digit is lit P_DIV−1 cycles per period.

## Configuration
- `DEC7SEG_LZ_BLANK_EN` defined: leading-zero blanking. Digit i>0 is blanked (`an` bit high, `seg`=7F, `dp`=1) when nibbles i..P_DIGITS-1 of `val_q` are all 0 and `dp_q[i]`=0. Digit 0 is never blanked.
- Not defined: every digit is always shown, including leading zeros. No blanking logic is synthesised.

## Test plan
All with P_DIGITS=4, P_DIV=4.
- Reset: assert `rst` 3 cycles mid-scan → `seg`=7F, `dp`=1, `an`=1111 during reset. First edge after release still blank; next edge `an`=1110, `seg`=40.
- Scan/decode: load `value`=0x1A3F, `dp_in`=0100 → repeating sequence of 3 lit cycles then 1 blank cycle:
  - `an`=1110 with `seg`=0E;
  - `an`=1101 with `seg`=30;
  - `an`=1011 with `seg`=08, `dp`=0;
  - `an`=0111 with `seg`=79.
- Load timing: strobe `load` with 0x0008 in the cycle `div_q`=3 while showing digit 0 → next cycle `an`=1101, `seg`=40. The following digit-0 slot shows `seg`=00.
- Enable: drop `en` for 6 cycles → `an`=1111 throughout. After re-raise, the digit shown matches the free-running index (no scan restart).
- Exhaustive decode: load each 0x0..0xF into digit 0 → `seg` matches the table for all 16 values.
- With `DEC7SEG_LZ_BLANK_EN`: load 0x0050 → digits 3 and 2 are `an`=1111 in their slots; digit 1 `seg`=12; digit 0 `seg`=40. Load 0x0000 → only digit 0 lit, showing `seg`=40. Without the macro, 0x0050 → all four digits lit.
